i2so_serializer: RTL and testbench

- I2S output transmitter: the other end of the i2si deserializer link.
- Accepts 16-bit left/right PCM pairs over a valid/ready handshake from the audio datapath, and generates serial clock, word select and serial data.
- Master-mode block: it generates i2so_sck and i2so_ws from clk.
- Line format is the one the deserializer expects: MSB first, ws high for right channel, ws leading the data by one bit.

---
 rtl/i2so_pkg.sv | 33 +++
 rtl/i2so_sck_gen.sv | 52 +++++
 rtl/i2so_serializer.sv | 174 +++++++++++++++++
 tb/tb_i2so_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2so_pkg.sv
// -----------------------------------------------------------------------------
// i2so_pkg
// Shared definitions for the I2S output serializer.
//   DEF_*         : default parameter values of the serializer.
//   DATA_W        : bits per channel word at the default configuration.
//   FRAME_SLOTS   : sck periods per stereo frame (left word + right word).
//   WS_RISE_SLOT  : first slot with ws high (left LSB, ws leads data by 1).
//   WS_FALL_SLOT  : first slot with ws low again (right LSB).
//   i2so_state_e  : serializer state.
//   ws_high()     : word-select level for a given slot of a frame.
// -----------------------------------------------------------------------------
package i2so_pkg;

  localparam int DEF_BIT_TC           = 15;
  localparam int DEF_CYC_PER_HALF_SCK = 40;

  localparam int DATA_W       = DEF_BIT_TC + 1;
  localparam int FRAME_SLOTS  = 2 * DATA_W;
  localparam int WS_RISE_SLOT = DATA_W - 1;
  localparam int WS_FALL_SLOT = FRAME_SLOTS - 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } i2so_state_e;

  // ws is high from the slot carrying the left LSB up to the slot before the
  // right LSB, so the channel change is announced one bit early.
  function automatic logic ws_high(input int slot, input int word_w);
    return (slot >= word_w - 1) && (slot <= 2 * word_w - 2);
  endfunction

endpackage

// File: rtl/i2so_sck_gen.sv
// -----------------------------------------------------------------------------
// i2so_sck_gen
// Serial clock generator for the I2S output serializer.
//   clk      in  : master clock.
//   rst_n    in  : asynchronous active-low reset.
//   run      in  : 1 = generate sck; 0 = hold sck low, counter cleared.
//   sck      out : serial clock, period 2*CYC_PER_HALF_SCK clk cycles.
//   sck_fall out : strobe, high in the clk cycle whose closing edge drops sck.
//   sck_rise out : strobe, high in the clk cycle whose closing edge raises sck.
// Both strobes are low whenever run is low.
// -----------------------------------------------------------------------------
module i2so_sck_gen
  import i2so_pkg::*;
#(
  parameter int CYC_PER_HALF_SCK = DEF_CYC_PER_HALF_SCK
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic sck,
  output logic sck_fall,
  output logic sck_rise
);

  localparam int HC_W = (CYC_PER_HALF_SCK > 1) ? $clog2(CYC_PER_HALF_SCK) : 1;
  localparam logic [HC_W-1:0] HC_LAST = HC_W'(CYC_PER_HALF_SCK - 1);

  logic [HC_W-1:0] hc;
  logic            half_done;

  assign half_done = run && (hc == HC_LAST);
  assign sck_fall  = half_done && sck;
  assign sck_rise  = half_done && !sck;

  // NOTE: every register below is updated with <= so all flops sample the
  // same pre-edge values; a blocking = here would create order-dependent logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hc  <= '0;
      sck <= 1'b0;
    end else if (!run) begin
      hc  <= '0;
      sck <= 1'b0;
    end else if (half_done) begin
      hc  <= '0;
      sck <= ~sck;
    end else begin
      hc  <= hc + 1'b1;
    end
  end

endmodule

// File: rtl/i2so_serializer.sv
// -----------------------------------------------------------------------------
// i2so_serializer
// I2S master transmitter: takes left/right PCM pairs over valid/ready and
// shifts them out MSB first, ws high for the right channel and leading the
// data by one bit. sd/ws change with the falling sck so they are stable at
// the receiver's rising-edge sample point.
//   clk         in  : master clock.
//   rst_n       in  : asynchronous active-low reset.
//   rf_i2so_en  in  : enable; 0 returns the block to IDLE on the next clk.
//   i2so_lft    in  : left sample, qualified by i2so_vld.
//   i2so_rgt    in  : right sample, qualified by i2so_vld.
//   i2so_vld    in  : sample pair valid.
//   i2so_rdy    out : holding register empty; transfer on vld & rdy.
//   i2so_sck    out : serial clock.
//   i2so_ws     out : word select (0 = left, 1 = right).
//   i2so_sd     out : serial data.
//   i2so_xfc    out : one-clk pulse when a frame has been fully shifted out.
//   i2so_unf    out : one-clk pulse when a frame started with no data (zeros).
// -----------------------------------------------------------------------------
module i2so_serializer
  import i2so_pkg::*;
#(
  parameter int CYC_PER_HALF_SCK = DEF_CYC_PER_HALF_SCK,
  parameter int BIT_TC           = DEF_BIT_TC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rf_i2so_en,
  input  logic [BIT_TC:0] i2so_lft,
  input  logic [BIT_TC:0] i2so_rgt,
  input  logic          i2so_vld,
  output logic          i2so_rdy,
  output logic          i2so_sck,
  output logic          i2so_ws,
  output logic          i2so_sd,
  output logic          i2so_xfc,
  output logic          i2so_unf
);

  localparam int WORD_W  = BIT_TC + 1;
  localparam int SHIFT_W = 2 * WORD_W;
  localparam int SLOT_W  = $clog2(SHIFT_W);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SHIFT_W - 1);

  i2so_state_e        state;
  logic               hold_full;
  logic [SHIFT_W-1:0] hold_data;
  logic [SHIFT_W-1:0] shift;
  logic [SHIFT_W-1:0] load_val;
  logic [SLOT_W-1:0]  slot;
  logic [SLOT_W-1:0]  slot_nxt;
  logic               run;
  logic               sck_fall;
  logic               sck_rise;
  logic               capture;
  logic               entry;
  logic               frame_end;
  logic               frame_load;

  // ---------------------------------------------------------------------------
  // Serial clock
  // ---------------------------------------------------------------------------
  // run is low on the entry edge (state still IDLE), so the half counter starts
  // at 0 on the first RUN cycle and slot 0 lasts a full sck period.
  assign run = (state == RUN) && rf_i2so_en;

  i2so_sck_gen #(
    .CYC_PER_HALF_SCK(CYC_PER_HALF_SCK)
  ) u_sck_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .sck      (i2so_sck),
    .sck_fall (sck_fall),
    .sck_rise (sck_rise)
  );

  // The two strobes decode opposite sck levels and can never coincide.
  a_strobe_excl : assert property (@(posedge clk) disable iff (!rst_n)
    !(sck_fall && sck_rise));

  // ---------------------------------------------------------------------------
  // Frame control decode
  // ---------------------------------------------------------------------------
  assign capture    = i2so_vld && i2so_rdy;
  assign i2so_rdy   = ~hold_full;
  assign entry      = (state == IDLE) && rf_i2so_en;
  assign frame_end  = sck_fall && (slot == SLOT_LAST);
  assign frame_load = entry || frame_end;

  // A load always sees the pre-edge holding register: a pair captured on the
  // same edge waits for the next frame, and this frame goes out as zeros.
  assign load_val   = hold_full ? hold_data : '0;
  assign slot_nxt   = (slot == SLOT_LAST) ? '0 : slot + 1'b1;

  // ---------------------------------------------------------------------------
  // Holding register
  // ---------------------------------------------------------------------------
  // Capture only happens while empty and a load only empties a full register,
  // so the two branches never compete for the same edge. Disabling the block
  // leaves the held pair in place for the next enable.
  // NOTE: the data flops are reset along with the flag so that a pair from
  // before a reset can never leak into a later frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_full <= 1'b0;
      hold_data <= '0;
    end else if (capture) begin
      hold_full <= 1'b1;
      hold_data <= {i2so_lft, i2so_rgt};
    end else if (frame_load && hold_full) begin
      hold_full <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Serializer FSM: shift register, slot counter, sd/ws and status pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      shift    <= '0;
      slot     <= '0;
      i2so_sd  <= 1'b0;
      i2so_ws  <= 1'b0;
      i2so_xfc <= 1'b0;
      i2so_unf <= 1'b0;
    end else begin
      i2so_xfc <= 1'b0;
      i2so_unf <= 1'b0;

      case (state)
        IDLE: begin
          slot    <= '0;
          i2so_ws <= 1'b0;
          if (rf_i2so_en) begin
            state    <= RUN;
            shift    <= load_val;
            i2so_sd  <= load_val[SHIFT_W-1];
            i2so_unf <= ~hold_full;
          end else begin
            shift   <= '0;
            i2so_sd <= 1'b0;
          end
        end

        RUN: begin
          if (!rf_i2so_en) begin
            state   <= IDLE;
            shift   <= '0;
            slot    <= '0;
            i2so_sd <= 1'b0;
            i2so_ws <= 1'b0;
          end else if (sck_fall) begin
            slot    <= slot_nxt;
            i2so_ws <= ws_high(int'(slot_nxt), WORD_W);
            if (frame_end) begin
              shift    <= load_val;
              i2so_sd  <= load_val[SHIFT_W-1];
              i2so_xfc <= 1'b1;
              i2so_unf <= ~hold_full;
            end else begin
              shift    <= shift << 1;
              i2so_sd  <= shift[SHIFT_W-2];
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2so_serializer.sv
// -----------------------------------------------------------------------------
// tb_i2so_serializer
// Self-checking bench for i2so_serializer. Accepted pairs are queued with the
// clk edge on which they were captured; at every frame load the oldest pair
// captured before that edge becomes the expected frame (else zeros + unf).
// A receiver samples sd/ws on each sck rise and the collected frame is
// compared against the expectation when xfc closes it.
// -----------------------------------------------------------------------------
module tb_i2so_serializer;
  import i2so_pkg::*;

  timeunit 1ns;
  timeprecision 1ps;

  localparam int HALF      = DEF_CYC_PER_HALF_SCK;
  localparam int SCK_PER   = 2 * HALF;
  localparam int FRAME_CYC = FRAME_SLOTS * SCK_PER;
  localparam logic [31:0] WS_PAT = 32'h0001_FFFE;  // slots 15..30 high, MSB = slot 0

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rf_i2so_en;
  logic [15:0] i2so_lft;
  logic [15:0] i2so_rgt;
  logic        i2so_vld;
  logic        i2so_rdy;
  logic        i2so_sck;
  logic        i2so_ws;
  logic        i2so_sd;
  logic        i2so_xfc;
  logic        i2so_unf;

  always #5 clk = ~clk;

  i2so_serializer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rf_i2so_en (rf_i2so_en),
    .i2so_lft   (i2so_lft),
    .i2so_rgt   (i2so_rgt),
    .i2so_vld   (i2so_vld),
    .i2so_rdy   (i2so_rdy),
    .i2so_sck   (i2so_sck),
    .i2so_ws    (i2so_ws),
    .i2so_sd    (i2so_sd),
    .i2so_xfc   (i2so_xfc),
    .i2so_unf   (i2so_unf)
  );

  typedef struct {
    logic [31:0] data;
    int          edge_no;
  } pair_t;

  pair_t       pair_q[$];
  int          n_chk  = 0;
  int          n_pass = 0;
  int          edge_n = 0;
  logic        en_seen = 1'b0;
  logic        m_run   = 1'b0;
  int          cyc     = 0;
  int          loads   = 0;
  logic [31:0] cur_exp = '0;
  logic [31:0] rx_sd   = '0;
  logic [31:0] rx_ws   = '0;
  int          rx_n    = 0;
  logic        prev_sck = 1'b0;
  int          prev_rise = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Edge bookkeeping: inputs change 1 ns after posedge, so values read here
  // are the ones the DUT sampled on this edge.
  always @(posedge clk) begin
    edge_n++;
    en_seen = rf_i2so_en;
  end

  task automatic model_load(input bit is_entry);
    logic  exp_unf;
    pair_t p;
    if (pair_q.size() != 0 && pair_q[0].edge_no < edge_n) begin
      p       = pair_q.pop_front();
      cur_exp = p.data;
      exp_unf = 1'b0;
    end else begin
      cur_exp = '0;
      exp_unf = 1'b1;
    end
    check(is_entry ? "unf_entry" : "unf_frame", i2so_unf, exp_unf);
    check(is_entry ? "xfc_entry" : "xfc_frame", i2so_xfc, is_entry ? 32'd0 : 32'd1);
    check("rdy_load", i2so_rdy, pair_q.size() == 0);
    loads++;
    cyc       = 0;
    rx_n      = 0;
    rx_sd     = '0;
    rx_ws     = '0;
    prev_rise = edge_n - HALF;
  endtask

  // Monitor / receiver, evaluated half a clk after each active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_run = 1'b0;
      pair_q.delete();
      rx_n  = 0;
    end else if (!m_run) begin
      if (en_seen) begin
        m_run = 1'b1;
        model_load(1'b1);
      end
    end else if (!en_seen) begin
      m_run = 1'b0;
      check("idle_sck", i2so_sck, 0);
      check("idle_ws",  i2so_ws,  0);
      check("idle_sd",  i2so_sd,  0);
      check("idle_xfc", i2so_xfc, 0);
    end else begin
      cyc++;
      if (cyc == FRAME_CYC) begin
        check("frame_bits", rx_n,  FRAME_SLOTS);
        check("frame_sd",   rx_sd, cur_exp);
        check("frame_ws",   rx_ws, WS_PAT);
        model_load(1'b0);
      end else begin
        if (i2so_xfc) check("xfc_spurious", i2so_xfc, 0);
        if (i2so_unf) check("unf_spurious", i2so_unf, 0);
        if (i2so_sck && !prev_sck) begin
          check("sck_period", edge_n - prev_rise, SCK_PER);
          prev_rise = edge_n;
          rx_sd = {rx_sd[30:0], i2so_sd};
          rx_ws = {rx_ws[30:0], i2so_ws};
          rx_n++;
        end
      end
    end
    prev_sck = i2so_sck;
  end

  // Offer one pair; returns 1 ns after the capturing edge with vld low, so
  // back-to-back calls keep vld high at every edge.
  task automatic send(input logic [31:0] d);
    bit ok = 1'b0;
    i2so_lft = d[31:16];
    i2so_rgt = d[15:0];
    i2so_vld = 1'b1;
    for (int n = 0; n < 3 * FRAME_CYC; n++) begin
      @(negedge clk);
      if (i2so_rdy) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (ok) begin
      pair_q.push_back('{data: d, edge_no: edge_n});
      check("rdy_after_cap", i2so_rdy, 0);
    end else begin
      check("send_timeout", 0, 1);
    end
    i2so_vld = 1'b0;
  endtask

  task automatic wait_loads(input int target);
    for (int n = 0; n < 6 * FRAME_CYC; n++) begin
      if (loads >= target) break;
      @(posedge clk);
      #1;
    end
    if (loads < target) check("wait_loads", loads, target);
  endtask

  task automatic wait_cyc(input int c);
    for (int n = 0; n < 2 * FRAME_CYC; n++) begin
      if (m_run && cyc >= c) break;
      @(posedge clk);
      #1;
    end
    if (!(m_run && cyc >= c)) check("wait_cyc", cyc, c);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n      = 1'b0;
    rf_i2so_en = 1'b0;
    i2so_vld   = 1'b0;
    i2so_lft   = '0;
    i2so_rgt   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sck", i2so_sck, 0);
    check("rst_ws",  i2so_ws,  0);
    check("rst_sd",  i2so_sd,  0);
    check("rst_xfc", i2so_xfc, 0);
    check("rst_unf", i2so_unf, 0);
    check("rst_rdy", i2so_rdy, 1);
    rst_n = 1'b1;

    // Pair loaded before enable, then a stream with vld held high.
    send(32'hAAAA_FFFF);
    rf_i2so_en = 1'b1;
    send(32'h1478_A3B9);
    send(32'hCDD7_BABA);
    send(32'h4444_AAAA);
    wait_loads(5);
    rf_i2so_en = 1'b0;

    // Enable with empty holding register, supply a pair mid-frame.
    repeat (3) @(posedge clk);
    #1;
    rf_i2so_en = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    send(32'h0001_FFFF);
    wait_loads(8);

    // Disable at slot 20 with a pair held; it goes out after re-enable.
    send(32'hF8D5_D55A);
    wait_cyc(20 * SCK_PER + 10);
    rf_i2so_en = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rf_i2so_en = 1'b1;
    wait_loads(10);

    // Asynchronous reset at slot 9 with a pair held.
    send(32'h1234_5678);
    wait_cyc(9 * SCK_PER + 20);
    rst_n      = 1'b0;
    rf_i2so_en = 1'b0;
    #1;
    check("arst_sck", i2so_sck, 0);
    check("arst_ws",  i2so_ws,  0);
    check("arst_sd",  i2so_sd,  0);
    check("arst_xfc", i2so_xfc, 0);
    check("arst_unf", i2so_unf, 0);
    check("arst_rdy", i2so_rdy, 1);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send(32'h5A5A_0F0F);
    rf_i2so_en = 1'b1;
    wait_loads(12);
    rf_i2so_en = 1'b0;
    repeat (5) @(posedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
